// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays out a change amount coin by coin, largest coin first, from a
// per-denomination inventory, and reports any amount it could not pay.
module vm_change_dispenser #(
  parameter int CENTS_W    = 8,
  parameter int INV_W      = 6,
  parameter int INIT_COUNT = 20,
  parameter int PULSE_LEN  = 2,
  parameter int GAP_LEN    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               change_valid,
  input  logic [CENTS_W-1:0] change_amount,
  output logic               change_ready,
  input  logic               refill,
  output logic [4:0]         coin_out,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [CENTS_W-1:0] shortfall,
  output logic [2:0]         state_dbg
);

  // Handshake: a request is accepted on any rising edge where change_valid=1 and
  // change_ready=1 (IDLE); change_valid at any other time is dropped, never queued.
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, FINISH} state_t;

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [INV_W-1:0] INIT_INV   = INV_W'(INIT_COUNT);

  state_t             state, state_nxt;
  logic [CENTS_W-1:0] remaining;
  logic [CENTS_W-1:0] shortfall_q;
  logic [INV_W-1:0]   inv [5];
  logic [2:0]         coin_idx;
  logic [2:0]         sel_idx;
  logic               sel_found;
  logic [CNT_W-1:0]   cnt;

  // Index 0..4 maps to 5c, 10c, 25c, 50c, 100c (same order as coin_out bits).
  function automatic int coin_value(input logic [2:0] idx);
    case (idx)
      3'd0:    return 5;
      3'd1:    return 10;
      3'd2:    return 25;
      3'd3:    return 50;
      default: return 100;
    endcase
  endfunction

  // Ascending scan, so the last hit is the largest payable coin still in stock.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (inv[i] != '0 && int'(remaining) >= coin_value(3'(i))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (change_valid) state_nxt = SELECT;
      SELECT:  state_nxt = sel_found ? PULSE : FINISH;
      PULSE:   if (cnt == PULSE_LAST) state_nxt = GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = SELECT;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining   <= '0;
      shortfall_q <= '0;
      coin_idx    <= '0;
      cnt         <= '0;
      for (int i = 0; i < 5; i++) inv[i] <= INIT_INV;
    end else begin
      case (state)
        IDLE: begin
          if (refill) begin
            for (int i = 0; i < 5; i++) inv[i] <= INIT_INV;
          end
          if (change_valid) begin
            remaining   <= change_amount;
            shortfall_q <= '0;
          end
        end
        SELECT: begin
          coin_idx <= sel_idx;
          cnt      <= '0;
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            // Coin is only booked once its full pulse has been driven.
            cnt           <= '0;
            remaining     <= remaining - CENTS_W'(coin_value(coin_idx));
            inv[coin_idx] <= inv[coin_idx] - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) cnt <= '0;
          else                 cnt <= cnt + 1'b1;
        end
        FINISH: shortfall_q <= remaining;
        default: ;
      endcase
    end
  end

  assign change_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign short        = (state == FINISH) && (remaining != '0);
  assign shortfall    = (state == FINISH) ? remaining : shortfall_q;
  assign coin_out     = (state == PULSE) ? (5'b00001 << coin_idx) : 5'b00000;
  assign state_dbg    = state;

endmodule
